// File: rtl/r2r_dac_slew_driver.sv
// Millivolt-to-code driver for an R-2R ladder DAC: scales a 0..FULL_SCALE_MV setpoint to a code,
// then slews the ladder output one LSB every STEP_CYCLES clocks until it reaches that code.
module r2r_dac_slew_driver #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned FULL_SCALE_MV = 3300,
    parameter int unsigned SCALE_K       = 20257,
    parameter int unsigned STEP_CYCLES   = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [15:0]      target_mV,
    output logic             ready,
    output logic             busy,
    output logic             settled,
    output logic [WIDTH-1:0] target_code,
    output logic [WIDTH-1:0] r2r_out
);

    localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STEP_CYCLES - 1);
    localparam logic [15:0] FullMv = 16'(FULL_SCALE_MV);
    localparam logic [31:0] RoundHalf = 32'h0002_0000;

    typedef enum logic [1:0] {StIdle, StMul, StRnd, StSlew} state_e;

    state_e            state_q, state_d;
    logic [15:0]       mv_q, mv_d;
    logic [31:0]       prod_q, prod_d;
    logic [WIDTH-1:0]  code_q, code_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              settled_q, settled_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [31:0]       round_sum;
    logic [31:0]       shifted;
    logic [WIDTH-1:0]  code_sat;
    logic [WIDTH-1:0]  step_out;
    logic              accept;

    // Fixed-point scale: code = round(mv * SCALE_K / 2^18), saturated to the ladder range.
    assign round_sum = prod_q + RoundHalf;
    assign shifted   = round_sum >> 18;
    assign code_sat  = (|(shifted >> WIDTH)) ? '1 : shifted[WIDTH-1:0];
    assign step_out  = (code_q > out_q) ? out_q + 1'b1 : out_q - 1'b1;

    assign ready       = enable && (state_q == StIdle || state_q == StSlew);
    assign busy        = (state_q != StIdle);
    assign accept      = load && ready;
    assign settled     = settled_q;
    assign target_code = code_q;
    assign r2r_out     = out_q;

    always_comb begin
        state_d   = state_q;
        mv_d      = mv_q;
        prod_d    = prod_q;
        code_d    = code_q;
        out_d     = out_q;
        settled_d = settled_q;
        cnt_d     = cnt_q;

        if (!enable) begin
            state_d   = StIdle;
            out_d     = '0;
            code_d    = '0;
            settled_d = 1'b0;
            cnt_d     = '0;
        end else if (accept) begin
            // Also covers retarget during a slew: the output holds and the new slew starts here.
            mv_d      = (target_mV > FullMv) ? FullMv : target_mV;
            settled_d = 1'b0;
            cnt_d     = '0;
            state_d   = StMul;
        end else begin
            unique case (state_q)
                StMul: begin
                    prod_d  = {16'd0, mv_q} * SCALE_K;
                    state_d = StRnd;
                end
                StRnd: begin
                    code_d = code_sat;
                    if (code_sat == out_q) begin
                        state_d   = StIdle;
                        settled_d = 1'b1;
                    end else begin
                        state_d = StSlew;
                    end
                end
                StSlew: begin
                    if (cnt_q == CntMax) begin
                        cnt_d = '0;
                        out_d = step_out;
                        if (step_out == code_q) begin
                            state_d   = StIdle;
                            settled_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            mv_q      <= '0;
            prod_q    <= '0;
            code_q    <= '0;
            out_q     <= '0;
            settled_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mv_q      <= mv_d;
            prod_q    <= prod_d;
            code_q    <= code_d;
            out_q     <= out_d;
            settled_q <= settled_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_r2r_dac_slew_driver.sv
// Directed bench for r2r_dac_slew_driver with STEP_CYCLES=4; inputs change 1ns after posedge,
// outputs are sampled at the same point (well away from the next active edge).
module tb_r2r_dac_slew_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] target_mV;
    logic        ready;
    logic        busy;
    logic        settled;
    logic [7:0]  target_code;
    logic [7:0]  r2r_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    r2r_dac_slew_driver #(
        .WIDTH        (8),
        .FULL_SCALE_MV(3300),
        .SCALE_K      (20257),
        .STEP_CYCLES  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .target_mV  (target_mV),
        .ready      (ready),
        .busy       (busy),
        .settled    (settled),
        .target_code(target_code),
        .r2r_out    (r2r_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        enable    = 1'b1;
        load      = 1'b0;
        target_mV = 16'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Present a setpoint for exactly one edge (E0), then walk through E1 and E2.
    task automatic do_load(input logic [15:0] mv);
        load      = 1'b1;
        target_mV = mv;
        tick();
        load = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        enable    = 1'b1;
        load      = 1'b0;
        target_mV = 16'd0;
        #3;
        tests++;
        if (r2r_out !== 8'd0 || target_code !== 8'd0 || settled !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: out=%0d code=%0d settled=%b busy=%b, want 0 0 0 0",
                     r2r_out, target_code, settled, busy);
        end
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: ready=%b want 1", ready);
        end
    endtask

    task automatic test_full_ramp();
        int bad;
        apply_reset();
        do_load(16'd3300);
        tests++;
        if (target_code !== 8'd255 || r2r_out !== 8'd0 || settled !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL ramp_e2: code=%0d out=%0d settled=%b busy=%b, want 255 0 0 1",
                     target_code, r2r_out, settled, busy);
        end
        bad = 0;
        for (int t = 1; t <= 1020; t++) begin
            tick();
            tests++;
            if (r2r_out !== 8'(t / 4) || settled !== (t == 1020)) begin
                fails++;
                if (bad < 4)
                    $display("FAIL ramp_step t=%0d: out=%0d settled=%b, want %0d %b",
                             t, r2r_out, settled, t / 4, (t == 1020));
                bad++;
            end
        end
        tests++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL ramp_done: busy=%b ready=%b, want 0 1", busy, ready);
        end
        tick();
        tick();
        tests++;
        if (r2r_out !== 8'd255 || settled !== 1'b1) begin
            fails++;
            $display("FAIL ramp_hold: out=%0d settled=%b, want 255 1", r2r_out, settled);
        end
    endtask

    task automatic test_scaling();
        apply_reset();
        load      = 1'b1;
        target_mV = 16'd1650;
        tick();
        load = 1'b0;
        tests++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mul_ready: ready=%b busy=%b, want 0 1", ready, busy);
        end
        tick();
        tick();
        tests++;
        if (target_code !== 8'd128 || ready !== 1'b1) begin
            fails++;
            $display("FAIL scale_1650: code=%0d ready=%b, want 128 1", target_code, ready);
        end
        do_load(16'd5000);
        tests++;
        if (target_code !== 8'd255) begin
            fails++;
            $display("FAIL scale_5000: code=%0d want 255", target_code);
        end
        do_load(16'd13);
        tests++;
        if (target_code !== 8'd1 || r2r_out !== 8'd0) begin
            fails++;
            $display("FAIL scale_13: code=%0d out=%0d, want 1 0", target_code, r2r_out);
        end
        tick();
        tick();
        tick();
        tests++;
        if (r2r_out !== 8'd0 || settled !== 1'b0) begin
            fails++;
            $display("FAIL step13_pre: out=%0d settled=%b, want 0 0", r2r_out, settled);
        end
        tick();
        tests++;
        if (r2r_out !== 8'd1 || settled !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL step13: out=%0d settled=%b busy=%b, want 1 1 0",
                     r2r_out, settled, busy);
        end
        do_load(16'd6);
        tests++;
        if (target_code !== 8'd0 || busy !== 1'b1 || settled !== 1'b0) begin
            fails++;
            $display("FAIL scale_6: code=%0d busy=%b settled=%b, want 0 1 0",
                     target_code, busy, settled);
        end
        for (int t = 0; t < 4; t++) tick();
        // Output is now 0; loading 0 must settle at E2 with no steps.
        do_load(16'd0);
        tests++;
        if (target_code !== 8'd0 || r2r_out !== 8'd0 || settled !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_load: code=%0d out=%0d settled=%b busy=%b, want 0 0 1 0",
                     target_code, r2r_out, settled, busy);
        end
        for (int t = 0; t < 8; t++) tick();
        tests++;
        if (r2r_out !== 8'd0 || settled !== 1'b1) begin
            fails++;
            $display("FAIL zero_hold: out=%0d settled=%b, want 0 1", r2r_out, settled);
        end
    endtask

    task automatic test_retarget();
        int bad;
        logic [7:0] prev;
        apply_reset();
        do_load(16'd3300);
        for (int t = 0; t < 400; t++) tick();
        tests++;
        if (r2r_out !== 8'd100) begin
            fails++;
            $display("FAIL retarget_pre: out=%0d want 100", r2r_out);
        end
        do_load(16'd660);
        tests++;
        if (target_code !== 8'd51 || r2r_out !== 8'd100 || settled !== 1'b0) begin
            fails++;
            $display("FAIL retarget_e2: code=%0d out=%0d settled=%b, want 51 100 0",
                     target_code, r2r_out, settled);
        end
        bad  = 0;
        prev = r2r_out;
        for (int t = 1; t <= 196; t++) begin
            tick();
            tests++;
            if (r2r_out !== 8'(100 - t / 4) || r2r_out > prev || settled !== (t == 196)) begin
                fails++;
                if (bad < 4)
                    $display("FAIL retarget_step t=%0d: out=%0d settled=%b, want %0d %b",
                             t, r2r_out, settled, 100 - t / 4, (t == 196));
                bad++;
            end
            prev = r2r_out;
        end
        for (int t = 0; t < 8; t++) tick();
        tests++;
        if (r2r_out !== 8'd51 || busy !== 1'b0 || settled !== 1'b1) begin
            fails++;
            $display("FAIL retarget_hold: out=%0d busy=%b settled=%b, want 51 0 1",
                     r2r_out, busy, settled);
        end
    endtask

    task automatic test_load_hold();
        apply_reset();
        load      = 1'b1;
        target_mV = 16'd1650;
        tick();
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_e0_ready: ready=%b want 0", ready);
        end
        target_mV = 16'd3300;
        tick();
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_e1_ready: ready=%b want 0", ready);
        end
        target_mV = 16'd660;
        tick();
        load = 1'b0;
        tests++;
        if (ready !== 1'b1 || target_code !== 8'd128) begin
            fails++;
            $display("FAIL hold_e2: ready=%b code=%0d, want 1 128", ready, target_code);
        end
        tick();
        tick();
        tests++;
        if (target_code !== 8'd128 || busy !== 1'b1) begin
            fails++;
            $display("FAIL hold_after: code=%0d busy=%b, want 128 1", target_code, busy);
        end
    endtask

    task automatic test_enable();
        apply_reset();
        do_load(16'd3300);
        for (int t = 0; t < 40; t++) tick();
        enable = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b0 || r2r_out !== 8'd10) begin
            fails++;
            $display("FAIL dis_comb: ready=%b out=%0d, want 0 10", ready, r2r_out);
        end
        tick();
        tests++;
        if (r2r_out !== 8'd0 || settled !== 1'b0 || target_code !== 8'd0 || busy !== 1'b0 ||
            ready !== 1'b0) begin
            fails++;
            $display("FAIL dis_edge: out=%0d settled=%b code=%0d busy=%b ready=%b, want 0 0 0 0 0",
                     r2r_out, settled, target_code, busy, ready);
        end
        load      = 1'b1;
        target_mV = 16'd3300;
        tick();
        load = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL dis_load: busy=%b want 0", busy);
        end
        enable = 1'b1;
        tick();
        do_load(16'd3300);
        tests++;
        if (target_code !== 8'd255 || r2r_out !== 8'd0) begin
            fails++;
            $display("FAIL reen_e2: code=%0d out=%0d, want 255 0", target_code, r2r_out);
        end
        for (int t = 0; t < 8; t++) tick();
        tests++;
        if (r2r_out !== 8'd2) begin
            fails++;
            $display("FAIL reen_ramp: out=%0d want 2", r2r_out);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_load(16'd3300);
        for (int t = 0; t < 148; t++) tick();
        tests++;
        if (r2r_out !== 8'd37) begin
            fails++;
            $display("FAIL areset_pre: out=%0d want 37", r2r_out);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (r2r_out !== 8'd0 || target_code !== 8'd0 || settled !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL areset_mid: out=%0d code=%0d settled=%b busy=%b, want 0 0 0 0",
                     r2r_out, target_code, settled, busy);
        end
        tick();
        reset = 1'b0;
        tick();
        tests++;
        if (r2r_out !== 8'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL areset_after: out=%0d busy=%b, want 0 0", r2r_out, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_ramp();
        test_scaling();
        test_retarget();
        test_load_hold();
        test_enable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
